rng_test_sequencer: RTL and testbench

RNG_TEST_SEQUENCER -- requirements
Module: rng_test_sequencer

---
 rtl/rng_test_pkg.sv | 19 +
 rtl/rng_test_sequencer_rct.sv | 51 +++++
 rtl/rng_test_sequencer.sv | 136 +++++++++++++
 tb/tb_rng_test_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_test_pkg.sv
// Shared types and default constants for the RNG health-test sequencer.
package rng_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_SETTLE,
    ST_SAMPLE
  } state_t;

  localparam int DEF_WINDOW     = 20000;
  localparam int DEF_SETTLE     = 3;
  localparam int DEF_FAIL_LIMIT = 3;
  localparam int DEF_RCT_CUTOFF = 32;

  localparam int CNT_W = 15;

endpackage

// File: rtl/rng_test_sequencer_rct.sv
// Repetition-count test: tracks the run length of identical accepted bits and
// latches a failure for the window once the run reaches CUTOFF.
module rng_rct
  import rng_test_pkg::*;
#(
  parameter int CUTOFF = DEF_RCT_CUTOFF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic data_bit,
  input  logic vld,
  output logic fail
);

  localparam logic [5:0] CUT = (CUTOFF > 63) ? 6'd63 : 6'(CUTOFF);

  logic [5:0] run_reg;
  logic [5:0] run_next;
  logic       last_reg;
  logic       fail_reg;

  // A run of zero means no bit seen yet this window, so the first bit starts a run of 1.
  always_comb begin
    run_next = run_reg;
    if (vld) begin
      if (run_reg != 6'd0 && data_bit == last_reg) begin
        run_next = (run_reg == 6'd63) ? run_reg : run_reg + 6'd1;
      end else begin
        run_next = 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      run_reg  <= 6'd0;
      last_reg <= 1'b0;
      fail_reg <= 1'b0;
    end else if (vld) begin
      run_reg  <= run_next;
      last_reg <= data_bit;
      if (run_next >= CUT) begin
        fail_reg <= 1'b1;
      end
    end
  end

  assign fail = fail_reg;

endmodule

// File: rtl/rng_test_sequencer.sv
// Windowed sequencer feeding raw entropy bits to a statistical test engine and
// tracking consecutive failures; define RNG_SEQ_RCT_EN to add a repetition-count test.
module rng_test_sequencer
  import rng_test_pkg::*;
#(
  parameter int WINDOW     = DEF_WINDOW,
  parameter int SETTLE     = DEF_SETTLE,
  parameter int FAIL_LIMIT = DEF_FAIL_LIMIT,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic       clr_alarm,
  input  logic       rand_bit,
  input  logic       rand_vld,
  output logic       rand_rdy,
  output logic       test_rst,
  output logic       test_bit,
  output logic       test_bit_vld,
  input  logic       test_pass,
  output logic       busy,
  output logic       done,
  output logic       verdict,
  output logic [1:0] fail_cnt,
  output logic       alarm
);

  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW - 1);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [1:0]       FAIL_LIM    = (FAIL_LIMIT > 3) ? 2'd3 : 2'(FAIL_LIMIT);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [7:0]       settle_cnt_reg;
  logic             done_reg;
  logic             verdict_reg;
  logic [1:0]       fail_cnt_reg;
  logic             alarm_reg;

  logic feed;
  logic accept;
  logic window_ok;
  logic alarm_set;

  assign feed   = (state_reg == ST_FEED);
  assign accept = feed & rand_vld;

`ifdef RNG_SEQ_RCT_EN
  logic rct_fail;

  rng_rct #(
    .CUTOFF(RCT_CUTOFF)
  ) u_rct (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_reg == ST_CLEAR),
    .data_bit (rand_bit),
    .vld      (accept),
    .fail     (rct_fail)
  );

  assign window_ok = test_pass & ~rct_fail;
`else
  assign window_ok = test_pass;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start || continuous) state_next = ST_CLEAR;
      ST_CLEAR:  state_next = ST_FEED;
      ST_FEED:   if (accept && bit_cnt_reg == WINDOW_LAST) state_next = ST_SETTLE;
      ST_SETTLE: if (settle_cnt_reg == SETTLE_LAST) state_next = ST_SAMPLE;
      ST_SAMPLE: state_next = continuous ? ST_CLEAR : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= '0;
      settle_cnt_reg <= '0;
      done_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == ST_SAMPLE);
      if (state_reg == ST_CLEAR) begin
        bit_cnt_reg <= '0;
      end else if (accept) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
      settle_cnt_reg <= (state_reg == ST_SETTLE) ? settle_cnt_reg + 8'd1 : 8'd0;
    end
  end

  // Alarm is raised one cycle after the failing window updates fail_cnt,
  // i.e. while done is still high; a set beats a simultaneous clear.
  assign alarm_set = done_reg & ~verdict_reg & (fail_cnt_reg >= FAIL_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      verdict_reg  <= 1'b0;
      fail_cnt_reg <= 2'd0;
      alarm_reg    <= 1'b0;
    end else begin
      if (state_reg == ST_SAMPLE) begin
        verdict_reg <= window_ok;
        if (window_ok) begin
          fail_cnt_reg <= 2'd0;
        end else if (fail_cnt_reg != 2'd3) begin
          fail_cnt_reg <= fail_cnt_reg + 2'd1;
        end
      end
      if (alarm_set) begin
        alarm_reg <= 1'b1;
      end else if (clr_alarm) begin
        alarm_reg <= 1'b0;
      end
    end
  end

  assign rand_rdy     = feed;
  assign test_bit     = feed & rand_bit;
  assign test_bit_vld = accept;
  assign test_rst     = rst | (state_reg == ST_CLEAR);
  assign busy         = (state_reg != ST_IDLE);
  assign done         = done_reg;
  assign verdict      = verdict_reg;
  assign fail_cnt     = fail_cnt_reg;
  assign alarm        = alarm_reg;

endmodule

// File: tb/tb_rng_test_sequencer.sv
// Directed testbench for rng_test_sequencer with WINDOW=8, SETTLE=3, RCT_CUTOFF=4.
module tb_rng_test_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       continuous;
  logic       clr_alarm;
  logic       rand_bit;
  logic       rand_vld;
  logic       rand_rdy;
  logic       test_rst;
  logic       test_bit;
  logic       test_bit_vld;
  logic       test_pass;
  logic       busy;
  logic       done;
  logic       verdict;
  logic [1:0] fail_cnt;
  logic       alarm;

  int n_cmp = 0;
  int n_bad = 0;

  int acc, trst, rdy, leak, berr, dat;

  rng_test_sequencer #(
    .WINDOW     (8),
    .SETTLE     (3),
    .FAIL_LIMIT (3),
    .RCT_CUTOFF (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .continuous   (continuous),
    .clr_alarm    (clr_alarm),
    .rand_bit     (rand_bit),
    .rand_vld     (rand_vld),
    .rand_rdy     (rand_rdy),
    .test_rst     (test_rst),
    .test_bit     (test_bit),
    .test_bit_vld (test_bit_vld),
    .test_pass    (test_pass),
    .busy         (busy),
    .done         (done),
    .verdict      (verdict),
    .fail_cnt     (fail_cnt),
    .alarm        (alarm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one window from the current cycle (c=0) until done is seen; no checks here.
  task automatic run_window(input logic [7:0] pat, input logic toggle, input logic pass,
                            output int accepted, output int trst_n, output int rdy_n,
                            output int leak_n, output int bit_err, output int done_at);
    logic [31:0] cv;
    accepted = 0; trst_n = 0; rdy_n = 0; leak_n = 0; bit_err = 0; done_at = -1;
    test_pass = pass;
    for (int c = 0; c < 100; c++) begin
      cv = c;
      if (c == 1) start = 1'b0;
      rand_vld = toggle ? cv[0] : 1'b1;
      rand_bit = pat[accepted & 7];
      #1;
      if (test_bit_vld) begin
        if (test_bit !== rand_bit) bit_err++;
        accepted++;
      end
      if (test_rst) trst_n++;
      if (rand_rdy) rdy_n++;
      if (test_bit_vld && !rand_rdy) leak_n++;
      if (c > 0 && done) begin
        done_at = c;
        break;
      end
      tick();
    end
    $display("window: bits=%0d done_at=%0d verdict=%0d fail_cnt=%0d alarm=%0d",
             accepted, done_at, verdict, fail_cnt, alarm);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; continuous = 1'b0; clr_alarm = 1'b0;
    rand_bit = 1'b0; rand_vld = 1'b0; test_pass = 1'b0;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0d want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%0d want=0", done); end
    n_cmp++; if (verdict !== 1'b0) begin n_bad++; $display("FAIL reset_verdict got=%0d want=0", verdict); end
    n_cmp++; if (fail_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_fail_cnt got=%0d want=0", fail_cnt); end
    n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL reset_alarm got=%0d want=0", alarm); end
    n_cmp++; if (rand_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rand_rdy got=%0d want=0", rand_rdy); end
    n_cmp++; if (test_bit_vld !== 1'b0) begin n_bad++; $display("FAIL reset_test_bit_vld got=%0d want=0", test_bit_vld); end
    n_cmp++; if (test_rst !== 1'b1) begin n_bad++; $display("FAIL reset_test_rst got=%0d want=1", test_rst); end
    rst = 1'b0;
    #1;
    n_cmp++; if (test_rst !== 1'b0) begin n_bad++; $display("FAIL idle_test_rst got=%0d want=0", test_rst); end
    tick();
  endtask

  task automatic test_single_window();
    start = 1'b1;
    run_window(8'b1011_0010, 1'b0, 1'b1, acc, trst, rdy, leak, berr, dat);
    rand_vld = 1'b0;
    n_cmp++; if (dat !== 14) begin n_bad++; $display("FAIL single_done_cycle got=%0d want=14", dat); end
    n_cmp++; if (acc !== 8) begin n_bad++; $display("FAIL single_bits got=%0d want=8", acc); end
    n_cmp++; if (trst !== 1) begin n_bad++; $display("FAIL single_test_rst_cycles got=%0d want=1", trst); end
    n_cmp++; if (rdy !== 8) begin n_bad++; $display("FAIL single_rdy_cycles got=%0d want=8", rdy); end
    n_cmp++; if (berr !== 0) begin n_bad++; $display("FAIL single_passthrough_errs got=%0d want=0", berr); end
    n_cmp++; if (verdict !== 1'b1) begin n_bad++; $display("FAIL single_verdict got=%0d want=1", verdict); end
    n_cmp++; if (fail_cnt !== 2'd0) begin n_bad++; $display("FAIL single_fail_cnt got=%0d want=0", fail_cnt); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL single_done_width got=%0d want=0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after got=%0d want=0", busy); end
  endtask

  task automatic test_stall();
    start = 1'b1;
    run_window(8'b0100_1101, 1'b1, 1'b1, acc, trst, rdy, leak, berr, dat);
    rand_vld = 1'b0;
    n_cmp++; if (acc !== 8) begin n_bad++; $display("FAIL stall_bits got=%0d want=8", acc); end
    n_cmp++; if (rdy !== 16) begin n_bad++; $display("FAIL stall_rdy_cycles got=%0d want=16", rdy); end
    n_cmp++; if (leak !== 0) begin n_bad++; $display("FAIL stall_vld_outside_feed got=%0d want=0", leak); end
    n_cmp++; if (dat !== 22) begin n_bad++; $display("FAIL stall_done_cycle got=%0d want=22", dat); end
    n_cmp++; if (verdict !== 1'b1) begin n_bad++; $display("FAIL stall_verdict got=%0d want=1", verdict); end
    tick();
  endtask

  task automatic test_start_ignored();
    rand_vld = 1'b0;
    start = 1'b1; tick();
    start = 1'b0; tick();
    start = 1'b1; tick();
    start = 1'b0;
    #1;
    n_cmp++; if (rand_rdy !== 1'b1) begin n_bad++; $display("FAIL ignore_in_feed got=%0d want=1", rand_rdy); end
    run_window(8'b1010_0110, 1'b0, 1'b1, acc, trst, rdy, leak, berr, dat);
    rand_vld = 1'b0;
    n_cmp++; if (dat !== 12) begin n_bad++; $display("FAIL ignore_done_cycle got=%0d want=12", dat); end
    n_cmp++; if (acc !== 8) begin n_bad++; $display("FAIL ignore_bits got=%0d want=8", acc); end
    tick(); tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_no_restart got=%0d want=0", busy); end
  endtask

  task automatic test_continuous_alarm();
    continuous = 1'b1;
    run_window(8'b1011_0010, 1'b0, 1'b0, acc, trst, rdy, leak, berr, dat);
    n_cmp++; if (dat !== 14) begin n_bad++; $display("FAIL cont1_done_cycle got=%0d want=14", dat); end
    n_cmp++; if (fail_cnt !== 2'd1) begin n_bad++; $display("FAIL cont1_fail_cnt got=%0d want=1", fail_cnt); end
    n_cmp++; if (verdict !== 1'b0) begin n_bad++; $display("FAIL cont1_verdict got=%0d want=0", verdict); end
    run_window(8'b0110_1001, 1'b0, 1'b0, acc, trst, rdy, leak, berr, dat);
    n_cmp++; if (dat !== 13) begin n_bad++; $display("FAIL cont2_done_cycle got=%0d want=13", dat); end
    n_cmp++; if (fail_cnt !== 2'd2) begin n_bad++; $display("FAIL cont2_fail_cnt got=%0d want=2", fail_cnt); end
    run_window(8'b1011_0010, 1'b0, 1'b0, acc, trst, rdy, leak, berr, dat);
    rand_vld = 1'b0;
    n_cmp++; if (fail_cnt !== 2'd3) begin n_bad++; $display("FAIL cont3_fail_cnt got=%0d want=3", fail_cnt); end
    n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL cont3_alarm_early got=%0d want=0", alarm); end
    clr_alarm = 1'b1; tick(); clr_alarm = 1'b0;
    n_cmp++; if (alarm !== 1'b1) begin n_bad++; $display("FAIL alarm_set_wins got=%0d want=1", alarm); end
    clr_alarm = 1'b1; tick(); clr_alarm = 1'b0;
    n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL alarm_clear got=%0d want=0", alarm); end
    continuous = 1'b0;
    run_window(8'b0110_1001, 1'b0, 1'b0, acc, trst, rdy, leak, berr, dat);
    rand_vld = 1'b0;
    n_cmp++; if (dat !== 12) begin n_bad++; $display("FAIL cont4_done_cycle got=%0d want=12", dat); end
    n_cmp++; if (fail_cnt !== 2'd3) begin n_bad++; $display("FAIL cont4_fail_cnt_sat got=%0d want=3", fail_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cont4_idle got=%0d want=0", busy); end
    tick();
  endtask

  task automatic test_pass_after_fail();
    start = 1'b1;
    run_window(8'b1010_0110, 1'b0, 1'b1, acc, trst, rdy, leak, berr, dat);
    rand_vld = 1'b0;
    n_cmp++; if (fail_cnt !== 2'd0) begin n_bad++; $display("FAIL pass_fail_cnt got=%0d want=0", fail_cnt); end
    n_cmp++; if (verdict !== 1'b1) begin n_bad++; $display("FAIL pass_verdict got=%0d want=1", verdict); end
    tick();
  endtask

  task automatic test_reset_mid_feed();
    int seen;
    rand_vld = 1'b1; rand_bit = 1'b0;
    start = 1'b1; tick();
    start = 1'b0; tick(); tick(); tick();
    n_cmp++; if (rand_rdy !== 1'b1) begin n_bad++; $display("FAIL midrst_in_feed got=%0d want=1", rand_rdy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (test_rst !== 1'b1) begin n_bad++; $display("FAIL midrst_test_rst got=%0d want=1", test_rst); end
    tick();
    rst = 1'b0; rand_vld = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%0d want=0", busy); end
    n_cmp++; if (rand_rdy !== 1'b0) begin n_bad++; $display("FAIL midrst_rand_rdy got=%0d want=0", rand_rdy); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) seen++;
      tick();
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_done got=%0d want=0", seen); end
    start = 1'b1;
    run_window(8'b1011_0010, 1'b0, 1'b1, acc, trst, rdy, leak, berr, dat);
    rand_vld = 1'b0;
    n_cmp++; if (dat !== 14) begin n_bad++; $display("FAIL midrst_next_done got=%0d want=14", dat); end
    n_cmp++; if (acc !== 8) begin n_bad++; $display("FAIL midrst_next_bits got=%0d want=8", acc); end
    tick();
  endtask

  task automatic test_rct();
    logic exp_v;
`ifdef RNG_SEQ_RCT_EN
    exp_v = 1'b0;
`else
    exp_v = 1'b1;
`endif
    start = 1'b1;
    run_window(8'b0100_1111, 1'b0, 1'b1, acc, trst, rdy, leak, berr, dat);
    rand_vld = 1'b0;
    n_cmp++; if (dat !== 14) begin n_bad++; $display("FAIL rct_done_cycle got=%0d want=14", dat); end
    n_cmp++; if (verdict !== exp_v) begin n_bad++; $display("FAIL rct_verdict got=%0d want=%0d", verdict, exp_v); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_stall();
    test_start_ignored();
    test_continuous_alarm();
    test_pass_after_fail();
    test_reset_mid_feed();
    test_rct();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
